encoder_pool_stage: RTL and testbench

Parametrised successor to the encoder stage control. It sits directly after the conv block in each U-Net encoder level and consumes its channel-interleaved, raster-order feature stream. It forwards every element unchanged on a skip stream to the decoder, and produces a 2x2/stride-2 downsampled stream for the next level. Pooling mode is selectable per frame (max, average, bypass), and all three streams use valid/ready backpressure.

---
 rtl/encoder_pool_stage_pkg.sv | 26 ++
 rtl/encoder_pool_stage_row_buffer.sv | 24 ++
 rtl/encoder_pool_stage.sv | 192 +++++++++++++++++++
 tb/tb_encoder_pool_stage.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/encoder_pool_stage_pkg.sv
// Shared types and helpers for the U-Net encoder pooling stage.
// Pooling arithmetic is done on 32-bit signed values; callers sign-extend and truncate.
package encoder_pkg;

  localparam logic [1:0] MODE_MAX    = 2'd0;
  localparam logic [1:0] MODE_AVG    = 2'd1;
  localparam logic [1:0] MODE_BYPASS = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  // Accumulate one element into a partial window result.
  function automatic logic signed [31:0] pool_combine(
    input logic [1:0]         mode,
    input logic signed [31:0] a,
    input logic signed [31:0] b
  );
    if (mode == MODE_AVG) return a + b;
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/encoder_pool_stage_row_buffer.sv
// Row buffer holding partial 2x2 window results for one pooled output row.
// Combinational read, synchronous write; maps onto distributed RAM.
module pool_row_buffer #(
  parameter int DEPTH  = 256,
  parameter int WIDTH  = 18,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/encoder_pool_stage.sv
// Encoder level pooling stage: forwards every element on the skip stream and
// emits a 2x2/stride-2 max/avg (or bypass) stream, both with valid/ready.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for start; inputs not accepted
// S_RUN   | accepting the frame's H*W*C elements
// S_DRAIN | all elements taken; waiting for both output registers to empty
// S_DONE  | one-cycle done pulse, then back to S_IDLE
module encoder_pool_stage
  import encoder_pkg::*;
#(
  parameter int IMG_HEIGHT = 256,
  parameter int IMG_WIDTH  = 256,
  parameter int CHANNELS   = 64,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] skip_data,
  output logic                  skip_valid,
  input  logic                  skip_ready,
  output logic [DATA_WIDTH-1:0] pool_data,
  output logic                  pool_valid,
  input  logic                  pool_ready,
  output logic                  busy,
  output logic                  done
);

  localparam int ACC_W  = DATA_WIDTH + 2;
  localparam int DEPTH  = (IMG_WIDTH / 2) * CHANNELS;
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int COL_W  = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int ROW_W  = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  if (IMG_HEIGHT % 2 != 0) begin : g_chk_height
    $error("encoder_pool_stage: IMG_HEIGHT must be even");
  end
  if (IMG_WIDTH % 2 != 0) begin : g_chk_width
    $error("encoder_pool_stage: IMG_WIDTH must be even");
  end
  if (ACC_W >= 32) begin : g_chk_dw
    $error("encoder_pool_stage: DATA_WIDTH must be below 30");
  end

  state_e                state_q, state_d;
  logic [1:0]            mode_q, mode_d;
  logic [CH_W-1:0]       ch_cnt_q, ch_cnt_d;
  logic [COL_W-1:0]      col_cnt_q, col_cnt_d;
  logic [ROW_W-1:0]      row_cnt_q, row_cnt_d;
  logic                  skip_valid_q, skip_valid_d;
  logic [DATA_WIDTH-1:0] skip_data_q, skip_data_d;
  logic                  pool_valid_q, pool_valid_d;
  logic [DATA_WIDTH-1:0] pool_data_q, pool_data_d;

  logic                  accept, emit, last_elem, row_odd, col_odd, is_bypass;
  logic                  buf_we;
  logic [ADDR_W-1:0]     buf_idx;
  logic [ACC_W-1:0]      buf_rd, buf_wd, comb_acc, in_ext;
  logic [DATA_WIDTH-1:0] pool_final;

  assign row_odd   = row_cnt_q[0];
  assign col_odd   = col_cnt_q[0];
  assign is_bypass = (mode_q == MODE_BYPASS);
  assign emit      = is_bypass || (row_odd && col_odd);
  assign in_ready  = (state_q == S_RUN) && (!skip_valid_q || skip_ready)
                     && (!pool_valid_q || pool_ready || !emit);
  assign accept    = in_valid && in_ready;
  assign last_elem = (ch_cnt_q == CH_W'(CHANNELS - 1))
                     && (col_cnt_q == COL_W'(IMG_WIDTH - 1))
                     && (row_cnt_q == ROW_W'(IMG_HEIGHT - 1));

  assign buf_idx = ADDR_W'((32'(col_cnt_q) >> 1) * 32'(CHANNELS) + 32'(ch_cnt_q));
  assign in_ext  = {{2{in_data[DATA_WIDTH-1]}}, in_data};

  // Both operands are sign-extended to 32 bits; the sum of four fits in ACC_W.
  assign comb_acc = ACC_W'(pool_combine(mode_q,
                                        {{(32-ACC_W){buf_rd[ACC_W-1]}}, buf_rd},
                                        {{(32-ACC_W){in_ext[ACC_W-1]}}, in_ext}));

  always_comb begin
    pool_final = comb_acc[DATA_WIDTH-1:0];
    if (is_bypass)                pool_final = in_data;
    else if (mode_q == MODE_AVG)  pool_final = comb_acc[ACC_W-1:2];
  end

  assign buf_we = accept && !is_bypass && !(row_odd && col_odd);
  assign buf_wd = (!row_odd && !col_odd) ? in_ext : comb_acc;

  pool_row_buffer #(
    .DEPTH  (DEPTH),
    .WIDTH  (ACC_W),
    .ADDR_W (ADDR_W)
  ) u_row_buffer (
    .clk   (clk),
    .we    (buf_we),
    .waddr (buf_idx),
    .wdata (buf_wd),
    .raddr (buf_idx),
    .rdata (buf_rd)
  );

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    ch_cnt_d     = ch_cnt_q;
    col_cnt_d    = col_cnt_q;
    row_cnt_d    = row_cnt_q;
    skip_valid_d = skip_valid_q;
    skip_data_d  = skip_data_q;
    pool_valid_d = pool_valid_q;
    pool_data_d  = pool_data_q;

    if (skip_valid_q && skip_ready) skip_valid_d = 1'b0;
    if (pool_valid_q && pool_ready) pool_valid_d = 1'b0;

    if (accept) begin
      skip_valid_d = 1'b1;
      skip_data_d  = in_data;
      if (emit) begin
        pool_valid_d = 1'b1;
        pool_data_d  = pool_final;
      end
      if (ch_cnt_q == CH_W'(CHANNELS - 1)) begin
        ch_cnt_d = '0;
        if (col_cnt_q == COL_W'(IMG_WIDTH - 1)) begin
          col_cnt_d = '0;
          row_cnt_d = (row_cnt_q == ROW_W'(IMG_HEIGHT - 1)) ? '0 : row_cnt_q + ROW_W'(1);
        end else begin
          col_cnt_d = col_cnt_q + COL_W'(1);
        end
      end else begin
        ch_cnt_d = ch_cnt_q + CH_W'(1);
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_RUN;
          // Mode 3 is folded into max at latch time.
          mode_d    = (mode == MODE_AVG || mode == MODE_BYPASS) ? mode : MODE_MAX;
          ch_cnt_d  = '0;
          col_cnt_d = '0;
          row_cnt_d = '0;
        end
      end
      S_RUN:   if (accept && last_elem) state_d = S_DRAIN;
      S_DRAIN: if (!skip_valid_q && !pool_valid_q) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      mode_q       <= MODE_MAX;
      ch_cnt_q     <= '0;
      col_cnt_q    <= '0;
      row_cnt_q    <= '0;
      skip_valid_q <= 1'b0;
      skip_data_q  <= '0;
      pool_valid_q <= 1'b0;
      pool_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      ch_cnt_q     <= ch_cnt_d;
      col_cnt_q    <= col_cnt_d;
      row_cnt_q    <= row_cnt_d;
      skip_valid_q <= skip_valid_d;
      skip_data_q  <= skip_data_d;
      pool_valid_q <= pool_valid_d;
      pool_data_q  <= pool_data_d;
    end
  end

  assign skip_valid = skip_valid_q;
  assign skip_data  = skip_data_q;
  assign pool_valid = pool_valid_q;
  assign pool_data  = pool_data_q;
  assign busy       = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done       = (state_q == S_DONE);

endmodule

// File: tb/tb_encoder_pool_stage.sv
// Self-checking bench for encoder_pool_stage on a 4x4x2 frame against a
// window-level reference model (expected skip and pool queues per frame).
module tb_encoder_pool_stage;

  localparam int H  = 4;
  localparam int W  = 4;
  localparam int C  = 2;
  localparam int DW = 16;
  localparam int N  = H * W * C;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] skip_data;
  logic          skip_valid;
  logic          skip_ready = 1'b1;
  logic [DW-1:0] pool_data;
  logic          pool_valid;
  logic          pool_ready = 1'b1;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  encoder_pool_stage #(
    .IMG_HEIGHT (H),
    .IMG_WIDTH  (W),
    .CHANNELS   (C),
    .DATA_WIDTH (DW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .mode       (mode),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .skip_data  (skip_data),
    .skip_valid (skip_valid),
    .skip_ready (skip_ready),
    .pool_data  (pool_data),
    .pool_valid (pool_valid),
    .pool_ready (pool_ready),
    .busy       (busy),
    .done       (done)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  logic signed [DW-1:0] frame_mem [N];
  logic [DW-1:0]        exp_skip [$];
  logic [DW-1:0]        exp_pool [$];
  int                   cur_mode = 0;
  logic                 cur_emit = 1'b0;
  logic                 rand_ready = 1'b0;
  int                   done_cnt = 0;
  int                   done_base = 0;
  int                   stall_cnt = 0;

  function automatic int elem_idx(input int r, input int c, input int ch);
    return (r * W + c) * C + ch;
  endfunction

  function automatic int floor_div4(input int s);
    int rem;
    rem = ((s % 4) + 4) % 4;
    return (s - rem) / 4;
  endfunction

  // Reference: skip = input stream; pool = per-window max / floored mean, or the input in bypass.
  function automatic void build_expect(input int m);
    exp_skip.delete();
    exp_pool.delete();
    for (int i = 0; i < N; i++) exp_skip.push_back(frame_mem[i]);
    if (m == 2) begin
      for (int i = 0; i < N; i++) exp_pool.push_back(frame_mem[i]);
    end else begin
      for (int pr = 0; pr < H / 2; pr++)
        for (int pc = 0; pc < W / 2; pc++)
          for (int ch = 0; ch < C; ch++) begin
            int sum, mx, v;
            sum = 0;
            mx  = -(1 << 30);
            for (int dr = 0; dr < 2; dr++)
              for (int dc = 0; dc < 2; dc++) begin
                v   = int'(frame_mem[elem_idx(2 * pr + dr, 2 * pc + dc, ch)]);
                sum = sum + v;
                if (v > mx) mx = v;
              end
            exp_pool.push_back(DW'((m == 1) ? floor_div4(sum) : mx));
          end
    end
  endfunction

  function automatic void fill_ramp();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        frame_mem[elem_idx(r, c, 0)] = DW'(r * 4 + c);
        frame_mem[elem_idx(r, c, 1)] = DW'(-(r * 4 + c));
      end
  endfunction

  function automatic void fill_random();
    for (int i = 0; i < N; i++) frame_mem[i] = DW'($urandom);
  endfunction

  function automatic void fill_sat();
    fill_random();
    for (int dr = 0; dr < 2; dr++)
      for (int dc = 0; dc < 2; dc++) begin
        frame_mem[elem_idx(dr, dc, 0)]     = 16'sh7FFF;
        frame_mem[elem_idx(dr, 2 + dc, 1)] = 16'sh8000;
      end
  endfunction

  always @(posedge clk) begin
    #1;
    skip_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    pool_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  logic          sv_hold = 1'b0, pv_hold = 1'b0;
  logic [DW-1:0] sd_prev = '0, pd_prev = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      sv_hold = 1'b0;
      pv_hold = 1'b0;
    end else begin
      if (done) done_cnt++;
      if (busy && in_valid && !in_ready) stall_cnt++;
      if (sv_hold) begin
        chk("skip_hold_valid", skip_valid, 1);
        chk("skip_hold_data", skip_data, sd_prev);
      end
      if (pv_hold) begin
        chk("pool_hold_valid", pool_valid, 1);
        chk("pool_hold_data", pool_data, pd_prev);
      end
      if (in_ready && in_valid) begin
        chk("in_ready_vs_skip", !skip_valid || skip_ready, 1);
        if (pool_valid && !pool_ready) chk("in_ready_vs_pool", cur_emit, 0);
      end
      if (skip_valid && skip_ready) begin
        if (exp_skip.size() == 0) chk("skip_extra", skip_data, 32'hDEAD_BEEF);
        else chk("skip_data", skip_data, exp_skip.pop_front());
      end
      if (pool_valid && pool_ready) begin
        if (exp_pool.size() == 0) chk("pool_extra", pool_data, 32'hDEAD_BEEF);
        else chk("pool_data", pool_data, exp_pool.pop_front());
      end
      sv_hold = skip_valid && !skip_ready;
      pv_hold = pool_valid && !pool_ready;
      sd_prev = skip_data;
      pd_prev = pool_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input logic [1:0] m);
    cur_mode  = (m == 2'd1) ? 1 : (m == 2'd2) ? 2 : 0;
    build_expect(cur_mode);
    stall_cnt = 0;
    done_base = done_cnt;
    mode      = m;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    chk("busy_after_start", busy, 1);
  endtask

  task automatic feed(input int n_elems, input int start_at);
    for (int i = 0; i < n_elems; i++) begin
      int  budget;
      int  r, c;
      r        = i / (W * C);
      c        = (i / C) % W;
      in_data  = frame_mem[i];
      in_valid = 1'b1;
      cur_emit = (cur_mode == 2) || (r[0] && c[0]);
      if (i == start_at) begin
        start = 1'b1;
        mode  = 2'd2;
      end
      budget = 0;
      forever begin
        @(negedge clk);
        if (in_ready) break;
        budget++;
        if (budget > 500) break;
      end
      if (budget > 500) begin
        chk("accept_timeout", 0, 1);
        in_valid = 1'b0;
        start    = 1'b0;
        return;
      end
      tick();
      start = 1'b0;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk("done_seen", seen, 1);
  endtask

  task automatic run_frame(input logic [1:0] m, input logic rr, input int start_at);
    rand_ready = rr;
    start_frame(m);
    feed(N, start_at);
    wait_done();
    rand_ready = 1'b0;
    repeat (3) tick();
    chk("done_once", done_cnt - done_base, 1);
    chk("skip_left", exp_skip.size(), 0);
    chk("pool_left", exp_pool.size(), 0);
    chk("busy_idle", busy, 0);
    if (!rr) chk("no_stall", stall_cnt, 0);
  endtask

  task automatic check_outputs_zero();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_skip_valid", skip_valid, 0);
    chk("rst_skip_data", skip_data, 0);
    chk("rst_pool_valid", pool_valid, 0);
    chk("rst_pool_data", pool_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs_zero();
    tick();
    rst_n = 1'b1;
    tick();

    fill_ramp();   run_frame(2'd0, 1'b0, -1);
    fill_ramp();   run_frame(2'd1, 1'b0, -1);
    fill_ramp();   run_frame(2'd2, 1'b0, -1);
    fill_ramp();   run_frame(2'd0, 1'b1, -1);
    fill_sat();    run_frame(2'd1, 1'b1, -1);
    fill_sat();    run_frame(2'd0, 1'b0, -1);
    for (int m = 0; m < 3; m++) begin
      fill_random();
      run_frame(2'(m), 1'b1, -1);
    end
    fill_ramp();   run_frame(2'd3, 1'b0, 5);

    fill_ramp();
    start_frame(2'd0);
    feed(13, -1);
    rst_n = 1'b0;
    @(negedge clk);
    check_outputs_zero();
    tick();
    rst_n = 1'b1;
    exp_skip.delete();
    exp_pool.delete();
    in_valid = 1'b1;
    in_data  = 16'h1234;
    @(negedge clk);
    chk("post_reset_in_ready", in_ready, 0);
    chk("post_reset_busy", busy, 0);
    tick();
    in_valid = 1'b0;
    run_frame(2'd0, 1'b0, -1);

    fill_ramp();
    start_frame(2'd0);
    feed(N, -1);
    wait_done();
    chk("restart_skip_left", exp_skip.size(), 0);
    chk("restart_pool_left", exp_pool.size(), 0);
    start = 1'b1;
    mode  = 2'd2;
    tick();
    chk("start_on_done_ignored", busy, 0);
    cur_mode  = 2;
    build_expect(2);
    done_base = done_cnt;
    stall_cnt = 0;
    tick();
    start = 1'b0;
    chk("start_after_done_accepted", busy, 1);
    feed(N, -1);
    wait_done();
    repeat (3) tick();
    chk("restart_done_once", done_cnt - done_base, 1);
    chk("restart_bypass_skip_left", exp_skip.size(), 0);
    chk("restart_bypass_pool_left", exp_pool.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
